// File: rtl/ctrl_pipe.sv
// Control-signal pipeline: carries the decoded control bundle through the E, M and W
// stage registers, inserting bubbles on flush, load-use hazards and illegal opcodes.
module ctrl_pipe #(
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_valid,
  input  logic [3:0]      d_opcode,
  input  logic [RA_W-1:0] d_rs1,
  input  logic [RA_W-1:0] d_rs2,
  input  logic [RA_W-1:0] d_rd,
  input  logic            d_wbs,
  input  logic            d_mm,
  input  logic            d_wre,
  input  logic            d_wm,
  input  logic            d_am,
  input  logic            d_ni,
  input  logic            d_wme,
  input  logic            d_alu_mux,
  input  logic            d_alu_mux1,
  input  logic            d_rde,
  input  logic [2:0]      d_aluop,
  input  logic [1:0]      d_ri,
  input  logic            flush,
  output logic            stall_fd,
  output logic            e_valid,
  output logic [3:0]      e_opcode,
  output logic [RA_W-1:0] e_rd,
  output logic            e_wbs,
  output logic            e_mm,
  output logic            e_wre,
  output logic            e_wm,
  output logic            e_am,
  output logic            e_ni,
  output logic            e_wme,
  output logic            e_alu_mux,
  output logic            e_alu_mux1,
  output logic            e_rde,
  output logic [2:0]      e_aluop,
  output logic [1:0]      e_ri,
  output logic            m_valid,
  output logic [RA_W-1:0] m_rd,
  output logic            m_wbs,
  output logic            m_mm,
  output logic            m_wre,
  output logic            m_wm,
  output logic            m_am,
  output logic            m_wme,
  output logic            w_valid,
  output logic [RA_W-1:0] w_rd,
  output logic            w_wbs,
  output logic            w_wre,
  output logic            w_wm,
  output logic            illegal_op
);

  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  logic load_use;
  logic illegal_d;
  logic capture;
  logic wre_masked;
  logic wme_masked;

  // A load still in E cannot forward its data to a consumer sitting in decode.
  assign load_use = e_valid & e_wre & (e_opcode == OP_LDR) & d_valid &
                    ((d_rs1 == e_rd) | ((d_ri == 2'b00) & (d_rs2 == e_rd)));
  assign stall_fd = load_use & ~flush & ~rst;

  assign illegal_d  = (d_opcode >= 4'd13);
  assign capture    = d_valid & ~illegal_d & ~flush & ~load_use;
  assign wre_masked = d_wre & ~((d_opcode[3:2] == 2'b01) | (d_opcode == OP_STR));
  assign wme_masked = d_wme & (d_opcode == OP_STR);

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0; e_opcode <= '0; e_rd <= '0; e_wbs <= 1'b0; e_mm <= 1'b0;
      e_wre <= 1'b0; e_wm <= 1'b0; e_am <= 1'b0; e_ni <= 1'b0; e_wme <= 1'b0;
      e_alu_mux <= 1'b0; e_alu_mux1 <= 1'b0; e_rde <= 1'b0; e_aluop <= '0; e_ri <= '0;
      m_valid <= 1'b0; m_rd <= '0; m_wbs <= 1'b0; m_mm <= 1'b0; m_wre <= 1'b0;
      m_wm <= 1'b0; m_am <= 1'b0; m_wme <= 1'b0;
      w_valid <= 1'b0; w_rd <= '0; w_wbs <= 1'b0; w_wre <= 1'b0; w_wm <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (capture) begin
        e_valid <= 1'b1; e_opcode <= d_opcode; e_rd <= d_rd; e_wbs <= d_wbs;
        e_mm <= d_mm; e_wre <= wre_masked; e_wm <= d_wm; e_am <= d_am;
        e_ni <= d_ni; e_wme <= wme_masked; e_alu_mux <= d_alu_mux;
        e_alu_mux1 <= d_alu_mux1; e_rde <= d_rde; e_aluop <= d_aluop; e_ri <= d_ri;
      end else begin
        e_valid <= 1'b0; e_opcode <= '0; e_rd <= '0; e_wbs <= 1'b0; e_mm <= 1'b0;
        e_wre <= 1'b0; e_wm <= 1'b0; e_am <= 1'b0; e_ni <= 1'b0; e_wme <= 1'b0;
        e_alu_mux <= 1'b0; e_alu_mux1 <= 1'b0; e_rde <= 1'b0; e_aluop <= '0; e_ri <= '0;
      end
      // Only a capture that would otherwise have happened reports the bad opcode.
      illegal_op <= d_valid & illegal_d & ~flush & ~load_use;

      m_valid <= e_valid; m_rd <= e_rd; m_wbs <= e_wbs; m_mm <= e_mm;
      m_wre <= e_wre; m_wm <= e_wm; m_am <= e_am; m_wme <= e_wme;

      w_valid <= m_valid; w_rd <= m_rd; w_wbs <= m_wbs; w_wre <= m_wre; w_wm <= m_wm;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: a reference model predicts the E/M/W bundles
// and illegal_op for each driven cycle; predictions are queued and checked after the edge.
module tb_ctrl_pipe;
  localparam int RA_W = 4;

  typedef struct packed {
    logic            valid;
    logic [3:0]      opcode;
    logic [RA_W-1:0] rd;
    logic            wbs, mm, wre, wm, am, ni, wme, alu_mux, alu_mux1, rde;
    logic [2:0]      aluop;
    logic [1:0]      ri;
  } ebun_t;

  typedef struct packed {
    ebun_t e;
    ebun_t m;
    ebun_t w;
    logic  ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic d_valid;
  logic [3:0] d_opcode;
  logic [RA_W-1:0] d_rs1, d_rs2, d_rd;
  logic d_wbs, d_mm, d_wre, d_wm, d_am, d_ni, d_wme, d_alu_mux, d_alu_mux1, d_rde;
  logic [2:0] d_aluop;
  logic [1:0] d_ri;
  logic flush;
  logic stall_fd;
  logic e_valid;
  logic [3:0] e_opcode;
  logic [RA_W-1:0] e_rd;
  logic e_wbs, e_mm, e_wre, e_wm, e_am, e_ni, e_wme, e_alu_mux, e_alu_mux1, e_rde;
  logic [2:0] e_aluop;
  logic [1:0] e_ri;
  logic m_valid;
  logic [RA_W-1:0] m_rd;
  logic m_wbs, m_mm, m_wre, m_wm, m_am, m_wme;
  logic w_valid;
  logic [RA_W-1:0] w_rd;
  logic w_wbs, w_wre, w_wm;
  logic illegal_op;

  int total = 0;
  int bad = 0;

  ebun_t mod_e = '0, mod_m = '0, mod_w = '0;
  logic  mod_stall = 1'b0;
  exp_t  sb[$];

  always #5 clk = ~clk;

  ctrl_pipe #(.RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_wbs(d_wbs), .d_mm(d_mm), .d_wre(d_wre), .d_wm(d_wm), .d_am(d_am),
    .d_ni(d_ni), .d_wme(d_wme), .d_alu_mux(d_alu_mux), .d_alu_mux1(d_alu_mux1),
    .d_rde(d_rde), .d_aluop(d_aluop), .d_ri(d_ri), .flush(flush),
    .stall_fd(stall_fd),
    .e_valid(e_valid), .e_opcode(e_opcode), .e_rd(e_rd), .e_wbs(e_wbs),
    .e_mm(e_mm), .e_wre(e_wre), .e_wm(e_wm), .e_am(e_am), .e_ni(e_ni),
    .e_wme(e_wme), .e_alu_mux(e_alu_mux), .e_alu_mux1(e_alu_mux1),
    .e_rde(e_rde), .e_aluop(e_aluop), .e_ri(e_ri),
    .m_valid(m_valid), .m_rd(m_rd), .m_wbs(m_wbs), .m_mm(m_mm), .m_wre(m_wre),
    .m_wm(m_wm), .m_am(m_am), .m_wme(m_wme),
    .w_valid(w_valid), .w_rd(w_rd), .w_wbs(w_wbs), .w_wre(w_wre), .w_wm(w_wm),
    .illegal_op(illegal_op)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one decode slot for one clock, predict the outcome, then check it.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [RA_W-1:0] rs1,
                     input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd,
                     input logic [1:0] ri, input logic wbs, input logic wre,
                     input logic wme, input logic fl, input logic r);
    logic  lu;
    exp_t  x;
    exp_t  got;
    ebun_t nxt;
    rst = r; flush = fl; d_valid = v; d_opcode = op; d_rs1 = rs1; d_rs2 = rs2;
    d_rd = rd; d_ri = ri; d_wbs = wbs; d_wre = wre; d_wme = wme;
    {d_mm, d_wm, d_am, d_ni, d_alu_mux, d_alu_mux1, d_rde} = 7'($urandom);
    d_aluop = 3'($urandom);
    #1;
    lu = mod_e.valid && mod_e.wre && (mod_e.opcode == 4'd9) && v &&
         (rs1 == mod_e.rd || (ri == 2'b00 && rs2 == mod_e.rd));
    check_val("stall_fd", 64'(stall_fd), 64'(lu && !fl && !r));

    nxt = '0;
    x.ill = 1'b0;
    if (!r && !fl && !lu && v) begin
      if (op == 4'd13 || op == 4'd14 || op == 4'd15) begin
        x.ill = 1'b1;
      end else begin
        nxt.valid = 1'b1; nxt.opcode = op; nxt.rd = rd; nxt.wbs = wbs;
        nxt.mm = d_mm; nxt.wm = d_wm; nxt.am = d_am; nxt.ni = d_ni;
        nxt.alu_mux = d_alu_mux; nxt.alu_mux1 = d_alu_mux1; nxt.rde = d_rde;
        nxt.aluop = d_aluop; nxt.ri = ri;
        case (op)
          4'd4, 4'd5, 4'd6, 4'd7, 4'd10: nxt.wre = 1'b0;
          default:                       nxt.wre = wre;
        endcase
        nxt.wme = (op == 4'd10) ? wme : 1'b0;
      end
    end
    x.e = nxt;
    x.m = r ? '0 : mod_e;
    x.w = r ? '0 : mod_m;
    sb.push_back(x);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      check_val("e_bundle", 64'({e_valid, e_opcode, e_rd, e_wbs, e_mm, e_wre, e_wm,
                                 e_am, e_ni, e_wme, e_alu_mux, e_alu_mux1, e_rde,
                                 e_aluop, e_ri}), 64'(got.e));
      check_val("m_bundle", 64'({m_valid, m_rd, m_wbs, m_mm, m_wre, m_wm, m_am, m_wme}),
                64'({got.m.valid, got.m.rd, got.m.wbs, got.m.mm, got.m.wre,
                     got.m.wm, got.m.am, got.m.wme}));
      check_val("w_bundle", 64'({w_valid, w_rd, w_wbs, w_wre, w_wm}),
                64'({got.w.valid, got.w.rd, got.w.wbs, got.w.wre, got.w.wm}));
      check_val("illegal_op", 64'(illegal_op), 64'(got.ill));
      mod_w = got.w; mod_m = got.m; mod_e = got.e;
    end
    mod_stall = lu && !fl && !r;
    $display("cyc t=%0t rst=%0b fl=%0b v=%0b op=%h rd=%0d stall=%0b e_v=%0b e_rd=%0d m_rd=%0d w_rd=%0d ill=%0b",
             $time, r, fl, v, op, rd, stall_fd, e_valid, e_rd, m_rd, w_rd, illegal_op);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, '0, '0, '0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, fl, r, wbs, wre, wme;
    logic [3:0] op;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [1:0] ri;

    // Reset with a live add in decode, then release.
    cyc(1, 4'd1, 4'd0, 4'd0, 4'd3, 2'b00, 1, 1, 0, 0, 1);
    cyc(1, 4'd1, 4'd0, 4'd0, 4'd3, 2'b00, 1, 1, 0, 0, 1);
    cyc(1, 4'd1, 4'd0, 4'd0, 4'd3, 2'b00, 1, 1, 0, 0, 0);
    nop(3);
    // Flow: add then sub.
    cyc(1, 4'd1, 4'd1, 4'd2, 4'd3, 2'b00, 1, 1, 0, 0, 0);
    cyc(1, 4'd0, 4'd1, 4'd2, 4'd4, 2'b00, 1, 1, 0, 0, 0);
    nop(3);
    // Load-use through rs1: one stall, add re-presented.
    cyc(1, 4'd9, 4'd0, 4'd0, 4'd5, 2'b01, 0, 1, 0, 0, 0);
    cyc(1, 4'd1, 4'd5, 4'd0, 4'd6, 2'b00, 1, 1, 0, 0, 0);
    cyc(1, 4'd1, 4'd5, 4'd0, 4'd6, 2'b00, 1, 1, 0, 0, 0);
    nop(3);
    // rs2 match with immediate select: no hazard.
    cyc(1, 4'd9, 4'd0, 4'd0, 4'd5, 2'b01, 0, 1, 0, 0, 0);
    cyc(1, 4'd1, 4'd0, 4'd5, 4'd6, 2'b10, 1, 1, 0, 0, 0);
    nop(3);
    // Flush wins over a pending load-use.
    cyc(1, 4'd9, 4'd0, 4'd0, 4'd5, 2'b01, 0, 1, 0, 0, 0);
    cyc(1, 4'd8, 4'd5, 4'd5, 4'd7, 2'b00, 1, 1, 0, 1, 0);
    nop(3);
    // Write-enable masking.
    cyc(1, 4'd10, 4'd1, 4'd2, 4'd3, 2'b00, 0, 1, 1, 0, 0);
    cyc(1, 4'd4, 4'd1, 4'd2, 4'd3, 2'b00, 0, 1, 1, 0, 0);
    cyc(1, 4'd1, 4'd1, 4'd2, 4'd3, 2'b00, 1, 1, 1, 0, 0);
    nop(3);
    // Illegal opcode, normal and under flush.
    cyc(1, 4'd14, 4'd0, 4'd0, 4'd2, 2'b00, 1, 1, 1, 0, 0);
    nop(2);
    cyc(1, 4'd14, 4'd0, 4'd0, 4'd2, 2'b00, 1, 1, 1, 1, 0);
    nop(2);
    // Reset in mid-stream drops everything in flight.
    cyc(1, 4'd1, 4'd0, 4'd0, 4'd8, 2'b00, 1, 1, 0, 0, 0);
    cyc(1, 4'd2, 4'd0, 4'd0, 4'd9, 2'b00, 1, 1, 0, 0, 0);
    cyc(1, 4'd3, 4'd0, 4'd0, 4'd10, 2'b00, 1, 1, 0, 0, 1);
    nop(2);

    // Random traffic; decode is held while stalled, as upstream would.
    v = 0; op = '0; rs1 = '0; rs2 = '0; rd = '0; ri = '0; wbs = 0; wre = 0; wme = 0;
    for (int i = 0; i < 300; i++) begin
      if (!mod_stall) begin
        v   = ($urandom_range(0, 4) != 0);
        op  = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom);
        rs1 = 4'($urandom_range(0, 3));
        rs2 = 4'($urandom_range(0, 3));
        rd  = 4'($urandom_range(0, 3));
        ri  = 2'($urandom);
        {wbs, wre, wme} = 3'($urandom);
      end
      fl = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 39) == 0);
      cyc(v, op, rs1, rs2, rd, ri, wbs, wre, wme, fl, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
